// File: rtl/riscie_pkg.sv
// rtl/riscie_pkg.sv - shared state encoding, func3 size codes and MEM/WB field bundle
package riscie_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wb;
    logic        mem_to_reg;
    logic [31:0] rdata;
    logic [31:0] alu;
  } memwb_t;

endpackage

// File: rtl/stage4_mem_load_store_align.sv
// rtl/stage4_mem_load_store_align.sv - lane steering for loads/stores; STAGE4_SUBWORD_EN enables B/H sizes
module load_store_align
  import riscie_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

`ifdef STAGE4_SUBWORD_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata_word[8*addr_lo +: 8];
  assign lane_h = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

  always_comb begin
    be         = 4'hF;
    wdata      = store_data;
    load_data  = rdata_word;
    misaligned = (addr_lo != 2'b00);
    case (func3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        load_data  = (func3 == F3_B) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
        misaligned = 1'b0;
      end
      F3_H, F3_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = (func3 == F3_H) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end
`else
  // Word-only build: size code is irrelevant.
  logic unused_func3;
  assign unused_func3 = ^func3;
  assign be           = 4'hF;
  assign wdata        = store_data;
  assign load_data    = rdata_word;
  assign misaligned   = (addr_lo != 2'b00);
`endif

endmodule

// File: rtl/stage4_mem.sv
// rtl/stage4_mem.sv - memory-access stage: req/ack data bus, stall, MEM/WB register (option STAGE4_SUBWORD_EN)
module stage4_mem
  import riscie_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exmemValid,
  input  logic [31:0] exmemAlu,
  input  logic [31:0] exmemReg2,
  input  logic [4:0]  exmemRd,
  input  logic        exmemWb,
  input  logic        exmemMemRead,
  input  logic        exmemMemWrite,
  input  logic [2:0]  exmemFunc3,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemBe,
  input  logic        dmemAck,
  input  logic [31:0] dmemRdata,
  output logic        memStall,
  output logic [4:0]  memwbRd,
  output logic        memwbWb,
  output logic        memwbMemToReg,
  output logic [31:0] memwbRdata,
  output logic [31:0] memwbAlu,
  output logic        memErr
);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  memwb_t           memwb;
  logic             memop, is_load, misaligned, bad, abort, done;
  logic [31:0]      load_data;

  load_store_align u_align (
    .func3      (exmemFunc3),
    .addr_lo    (exmemAlu[1:0]),
    .store_data (exmemReg2),
    .rdata_word (dmemRdata),
    .be         (dmemBe),
    .wdata      (dmemWdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign memop   = exmemValid & (exmemMemRead | exmemMemWrite);
  assign is_load = exmemValid & exmemMemRead & ~exmemMemWrite;
  assign bad     = memop & misaligned;
  assign abort   = (state == ST_BUSY) & ~dmemAck & (cnt == CNT_W'(TIMEOUT - 1));

  // Request and stall are gated by reset so a held EX/MEM cannot drive the bus during reset.
  assign dmemReq  = rst_n & ((state == ST_BUSY) | (memop & ~misaligned));
  assign dmemWe   = memop & exmemMemWrite;
  assign dmemAddr = {exmemAlu[31:2], 2'b00};
  assign done     = (dmemReq & dmemAck) | bad | abort;
  assign memStall = rst_n & memop & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      memwb  <= '0;
      memErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (memop & ~misaligned & ~dmemAck) state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (dmemAck | abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (bad | abort) memErr <= 1'b1;
      // A stalled, faulted or aborted access leaves a bubble so forwarding never sees partial results.
      if (memStall | bad | abort) begin
        memwb <= '0;
      end else begin
        memwb.rd         <= exmemRd;
        memwb.wb         <= exmemWb & exmemValid;
        memwb.mem_to_reg <= is_load;
        memwb.rdata      <= is_load ? load_data : 32'h0;
        memwb.alu        <= exmemAlu;
      end
    end
  end

  assign memwbRd       = memwb.rd;
  assign memwbWb       = memwb.wb;
  assign memwbMemToReg = memwb.mem_to_reg;
  assign memwbRdata    = memwb.rdata;
  assign memwbAlu      = memwb.alu;

endmodule

// File: tb/tb_stage4_mem.sv
// tb/tb_stage4_mem.sv - directed table-driven bench for stage4_mem (expectations follow STAGE4_SUBWORD_EN)
module tb_stage4_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exmemValid, exmemWb, exmemMemRead, exmemMemWrite, dmemAck;
  logic [31:0] exmemAlu, exmemReg2, dmemRdata;
  logic [4:0]  exmemRd;
  logic [2:0]  exmemFunc3;
  logic        dmemReq, dmemWe, memStall, memwbWb, memwbMemToReg, memErr;
  logic [31:0] dmemAddr, dmemWdata, memwbRdata, memwbAlu;
  logic [3:0]  dmemBe;
  logic [4:0]  memwbRd;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stage4_mem #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .exmemValid(exmemValid), .exmemAlu(exmemAlu), .exmemReg2(exmemReg2),
    .exmemRd(exmemRd), .exmemWb(exmemWb), .exmemMemRead(exmemMemRead), .exmemMemWrite(exmemMemWrite),
    .exmemFunc3(exmemFunc3), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemBe(dmemBe), .dmemAck(dmemAck), .dmemRdata(dmemRdata),
    .memStall(memStall), .memwbRd(memwbRd), .memwbWb(memwbWb), .memwbMemToReg(memwbMemToReg),
    .memwbRdata(memwbRdata), .memwbAlu(memwbAlu), .memErr(memErr)
  );

  typedef struct {
    string       name;
    logic        valid, wb, mrd, mwr, ack;
    logic [31:0] alu, reg2, rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rdata;
    logic        e_wb, e_mtr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input string name, input logic valid, input logic [31:0] alu, input logic [31:0] reg2,
                     input logic [4:0] rd, input logic wb, input logic mrd, input logic mwr,
                     input logic [2:0] f3, input logic ack, input logic [31:0] rdata,
                     input logic e_req, input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wdata,
                     input logic e_wb, input logic e_mtr, input logic [31:0] e_rdata);
    vec_t v;
    v.name = name; v.valid = valid; v.alu = alu; v.reg2 = reg2; v.rd = rd; v.wb = wb;
    v.mrd = mrd; v.mwr = mwr; v.f3 = f3; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_wb = e_wb; v.e_mtr = e_mtr; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic valid, input logic [31:0] alu, input logic [31:0] reg2, input logic [4:0] rd,
                       input logic wb, input logic mrd, input logic mwr, input logic [2:0] f3,
                       input logic ack, input logic [31:0] rdata);
    exmemValid = valid; exmemAlu = alu; exmemReg2 = reg2; exmemRd = rd; exmemWb = wb;
    exmemMemRead = mrd; exmemMemWrite = mwr; exmemFunc3 = f3; dmemAck = ack; dmemRdata = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1;
    chk("rst_err", memErr, 0);
    chk("rst_req", dmemReq, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stalls, reqs;
    bit finished;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1;
    chk("reset_req", dmemReq, 0);
    chk("reset_stall", memStall, 0);
    chk("reset_wb", memwbWb, 0);
    chk("reset_rd", memwbRd, 0);
    chk("reset_alu", memwbAlu, 0);
    chk("reset_err", memErr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //  name         v  alu           reg2          rd wb rd wr f3      ack rdata         req we be       wdata         wb mtr rdata
    add("alu_op",    1, 32'h00001234, 32'h0,        5, 1, 0, 0, 3'b000, 0,  32'h0,        0,  0, 4'h0,    32'h0,        1, 0,  32'h0);
    add("bubble",    0, 32'h00000040, 32'h0,        7, 1, 0, 0, 3'b000, 0,  32'h0,        0,  0, 4'h0,    32'h0,        0, 0,  32'h0);
    add("sw",        1, 32'h00000200, 32'hCAFEF00D, 0, 0, 0, 1, 3'b010, 1,  32'h0,        1,  1, 4'hF,    32'hCAFEF00D, 0, 0,  32'h0);
    add("lw",        1, 32'h00000104, 32'h0,        3, 1, 1, 0, 3'b010, 1,  32'h11223344, 1,  0, 4'hF,    32'h0,        1, 1,  32'h11223344);
    add("rd_wr",     1, 32'h00000108, 32'h55,       4, 0, 1, 1, 3'b010, 1,  32'h99999999, 1,  1, 4'hF,    32'h55,       0, 0,  32'h0);
`ifdef STAGE4_SUBWORD_EN
    add("sb",        1, 32'h00000103, 32'h000000AB, 0, 0, 0, 1, 3'b000, 1,  32'h0,        1,  1, 4'b1000, 32'hABABABAB, 0, 0,  32'h0);
    add("lb",        1, 32'h00000101, 32'h0,        6, 1, 1, 0, 3'b000, 1,  32'h00008000, 1,  0, 4'b0010, 32'h0,        1, 1,  32'hFFFFFF80);
    add("lbu",       1, 32'h00000101, 32'h0,        6, 1, 1, 0, 3'b100, 1,  32'h00008000, 1,  0, 4'b0010, 32'h0,        1, 1,  32'h00000080);
    add("sh",        1, 32'h00000102, 32'h1234BEEF, 0, 0, 0, 1, 3'b001, 1,  32'h0,        1,  1, 4'b1100, 32'hBEEFBEEF, 0, 0,  32'h0);
    add("lh",        1, 32'h00000102, 32'h0,        8, 1, 1, 0, 3'b001, 1,  32'h80010000, 1,  0, 4'b1100, 32'h0,        1, 1,  32'hFFFF8001);
    add("lhu",       1, 32'h00000100, 32'h0,        8, 1, 1, 0, 3'b101, 1,  32'h0000F00F, 1,  0, 4'b0011, 32'h0,        1, 1,  32'h0000F00F);
`else
    add("sb_word",   1, 32'h00000100, 32'h000000AB, 0, 0, 0, 1, 3'b000, 1,  32'h0,        1,  1, 4'hF,    32'h000000AB, 0, 0,  32'h0);
    add("lb_word",   1, 32'h00000100, 32'h0,        6, 1, 1, 0, 3'b000, 1,  32'h00008000, 1,  0, 4'hF,    32'h0,        1, 1,  32'h00008000);
`endif

    foreach (vecs[i]) begin
      vec_t v = vecs[i];
      @(negedge clk);
      drive(v.valid, v.alu, v.reg2, v.rd, v.wb, v.mrd, v.mwr, v.f3, v.ack, v.rdata);
      #1;
      chk({v.name, "_req"}, dmemReq, v.e_req);
      chk({v.name, "_stall"}, memStall, 0);
      if (v.e_req) begin
        chk({v.name, "_we"}, dmemWe, v.e_we);
        chk({v.name, "_addr"}, dmemAddr, {v.alu[31:2], 2'b00});
        chk({v.name, "_be"}, dmemBe, v.e_be);
        if (v.e_we) chk({v.name, "_wdata"}, dmemWdata, v.e_wdata);
      end
      @(posedge clk);
      #1;
      chk({v.name, "_mrd"}, memwbRd, v.rd);
      chk({v.name, "_mwb"}, memwbWb, v.e_wb);
      chk({v.name, "_mtr"}, memwbMemToReg, v.e_mtr);
      chk({v.name, "_mrdata"}, memwbRdata, v.e_rdata);
      chk({v.name, "_malu"}, memwbAlu, v.alu);
      chk({v.name, "_err"}, memErr, 0);
    end

    // LW with three wait cycles: three stalls with bubbles, then the load completes.
    @(negedge clk);
    drive(1, 32'h100, 0, 10, 1, 1, 0, 3'b010, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lw_wait_req", dmemReq, 1);
      chk("lw_wait_stall", memStall, 1);
      @(posedge clk);
      #1;
      chk("lw_wait_bubble", memwbWb, 0);
      @(negedge clk);
    end
    dmemAck = 1'b1; dmemRdata = 32'hDEADBEEF;
    #1;
    chk("lw_ack_stall", memStall, 0);
    @(posedge clk);
    #1;
    chk("lw_done_rdata", memwbRdata, 32'hDEADBEEF);
    chk("lw_done_mtr", memwbMemToReg, 1);
    chk("lw_done_wb", memwbWb, 1);
    chk("lw_done_rd", memwbRd, 10);

    // Misaligned word load: no request, no stall, sticky error, bubble.
    @(negedge clk);
    drive(1, 32'h102, 0, 11, 1, 1, 0, 3'b010, 0, 0);
    #1;
    chk("mis_req", dmemReq, 0);
    chk("mis_stall", memStall, 0);
    @(posedge clk);
    #1;
    chk("mis_err", memErr, 1);
    chk("mis_wb", memwbWb, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    @(posedge clk);
    #1;
    chk("mis_err_sticky", memErr, 1);

    do_reset();

    // Never-acked load: 1 request cycle plus 16 BUSY cycles, the last one aborts without stalling.
    drive(1, 32'h100, 0, 9, 1, 1, 0, 3'b010, 0, 0);
    stalls = 0; reqs = 0; finished = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (dmemReq) reqs++;
      if (!memStall) begin
        finished = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    chk("to_finished", finished, 1);
    chk("to_stalls", stalls, 16);
    chk("to_reqs", reqs, 17);
    @(posedge clk);
    #1;
    chk("to_err", memErr, 1);
    chk("to_wb", memwbWb, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    #1;
    chk("to_req_drop", dmemReq, 0);

    // Asynchronous reset in the middle of a BUSY access.
    @(negedge clk);
    drive(1, 32'h100, 0, 12, 1, 1, 0, 3'b010, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("mid_busy_req", dmemReq, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", dmemReq, 0);
    chk("arst_stall", memStall, 0);
    chk("arst_err", memErr, 0);
    chk("arst_wb", memwbWb, 0);
    chk("arst_rd", memwbRd, 0);
    chk("arst_mtr", memwbMemToReg, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    dmemAck = 1'b1; dmemRdata = 32'h12345678;
    #1;
    chk("late_ack_req", dmemReq, 0);
    @(posedge clk);
    #1;
    chk("late_ack_wb", memwbWb, 0);
    chk("late_ack_rdata", memwbRdata, 0);
    chk("late_ack_err", memErr, 0);
    @(negedge clk);
    dmemAck = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_ack_req", dmemReq, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
